mlp_param_loader: RTL and testbench

//   Writer side of the layer weight/bias register files: accepts a valid/ready

---
 rtl/mlp_param_loader.sv | 116 +++++++++++
 tb/tb_mlp_param_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_param_loader.sv
// Writer side of one layer's weight/bias register files: turns a valid/ready
// word stream into weight writes at {neuron, input_idx} and bias writes at neuron.
//
// state  | meaning
// IDLE   | waiting for start, stream not accepted
// WEIGHT | accepting weight words idx 0..NUM_INPUTS-1 of the current neuron
// BIAS   | accepting the single bias word of the current neuron
// DONE   | one cycle after the last bias, raises done and drops busy
module mlp_param_loader #(
    parameter int DATA_W      = 16,
    parameter int NUM_NEURONS = 200,
    parameter int NUM_INPUTS  = 784,
    parameter int NEURON_AW   = 8,
    parameter int INPUT_AW    = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    output logic                          w_we,
    output logic [NEURON_AW+INPUT_AW-1:0] w_addr,
    output logic [DATA_W-1:0]             w_data,
    output logic                          b_we,
    output logic [NEURON_AW-1:0]          b_addr,
    output logic [DATA_W-1:0]             b_data,
    output logic                          busy,
    output logic                          done,
    output logic [DATA_W-1:0]             checksum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WEIGHT,
        S_BIAS,
        S_DONE
    } state_t;

    localparam logic [INPUT_AW-1:0]  LAST_IDX    = INPUT_AW'(NUM_INPUTS - 1);
    localparam logic [NEURON_AW-1:0] LAST_NEURON = NEURON_AW'(NUM_NEURONS - 1);

    state_t               state;
    logic [NEURON_AW-1:0] neuron;
    logic [INPUT_AW-1:0]  idx;

    // Ready depends only on state, so the host never sees it flicker mid-load.
    assign in_ready = (state == S_WEIGHT) || (state == S_BIAS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            neuron   <= '0;
            idx      <= '0;
            w_we     <= 1'b0;
            w_addr   <= '0;
            w_data   <= '0;
            b_we     <= 1'b0;
            b_addr   <= '0;
            b_data   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            checksum <= '0;
        end else begin
            w_we <= 1'b0;
            b_we <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_WEIGHT;
                        neuron   <= '0;
                        idx      <= '0;
                        checksum <= '0;
                        busy     <= 1'b1;
                    end
                end
                S_WEIGHT: begin
                    if (in_valid) begin
                        w_we     <= 1'b1;
                        w_addr   <= {neuron, idx};
                        w_data   <= in_data;
                        checksum <= checksum + in_data;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= S_BIAS;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_BIAS: begin
                    if (in_valid) begin
                        b_we     <= 1'b1;
                        b_addr   <= neuron;
                        b_data   <= in_data;
                        checksum <= checksum + in_data;
                        if (neuron == LAST_NEURON) begin
                            state <= S_DONE;
                        end else begin
                            neuron <= neuron + 1'b1;
                            state  <= S_WEIGHT;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_param_loader.sv
// Bench for mlp_param_loader on a 2-neuron x 3-input layer, checked cycle by
// cycle against a beat-count model of the expected regfile write stream.
module tb_mlp_param_loader;

    localparam int DW = 16;
    localparam int NN = 2;
    localparam int NI = 3;
    localparam int NAW = 2;
    localparam int IAW = 2;
    localparam int TOTAL = NN * (NI + 1);

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic           in_valid = 1'b0;
    logic [DW-1:0]  in_data = '0;
    logic           in_ready;
    logic           w_we;
    logic [NAW+IAW-1:0] w_addr;
    logic [DW-1:0]  w_data;
    logic           b_we;
    logic [NAW-1:0] b_addr;
    logic [DW-1:0]  b_data;
    logic           busy;
    logic           done;
    logic [DW-1:0]  checksum;

    int n_chk = 0;
    int n_bad = 0;

    mlp_param_loader #(
        .DATA_W(DW), .NUM_NEURONS(NN), .NUM_INPUTS(NI),
        .NEURON_AW(NAW), .INPUT_AW(IAW)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .b_we(b_we), .b_addr(b_addr), .b_data(b_data),
        .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the load is a sequence of TOTAL beats; beat b belongs to
    // neuron b/(NI+1), and position NI within that group is the bias.
    bit        m_busy = 0;
    bit        m_loading = 0;
    bit        m_tail = 0;
    int        m_beats = 0;
    logic [DW-1:0] m_sum = '0;
    bit        e_w_we = 0, e_b_we = 0, e_done = 0;
    int        e_w_addr = 0, e_b_addr = 0;
    logic [DW-1:0] e_data = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_loading = 0; m_tail = 0; m_beats = 0; m_sum = '0;
            e_w_we = 0; e_b_we = 0; e_done = 0;
        end else begin
            e_w_we = 0; e_b_we = 0; e_done = 0;
            if (m_tail) begin
                m_tail = 0; m_busy = 0; e_done = 1;
            end else if (!m_busy && start) begin
                m_busy = 1; m_loading = 1; m_beats = 0; m_sum = '0;
            end else if (m_loading && in_valid) begin
                int n, r;
                n = m_beats / (NI + 1);
                r = m_beats % (NI + 1);
                e_data = in_data;
                m_sum = m_sum + in_data;
                if (r < NI) begin
                    e_w_we = 1; e_w_addr = n * (1 << IAW) + r;
                end else begin
                    e_b_we = 1; e_b_addr = n;
                end
                m_beats++;
                if (m_beats == TOTAL) begin
                    m_loading = 0; m_tail = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, m_loading);
        chk("w_we", w_we, e_w_we);
        chk("b_we", b_we, e_b_we);
        chk("we_excl", w_we & b_we, 0);
        chk("busy", busy, m_busy);
        chk("done", done, e_done);
        chk("checksum", checksum, m_sum);
        if (e_w_we) begin
            chk("w_addr", w_addr, e_w_addr);
            chk("w_data", w_data, e_data);
        end
        if (e_b_we) begin
            chk("b_addr", b_addr, e_b_addr);
            chk("b_data", b_data, e_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gap_mode: 0 back-to-back, 1 valid every other cycle, 2 valid asserted
    // together with start, 3 random gaps. stray_at: beat before which start is re-pulsed.
    task automatic run_load(input logic [DW-1:0] words [TOTAL], input int gap_mode,
                            input int stray_at);
        bit seen;
        start = 1'b1;
        in_valid = (gap_mode == 2);
        in_data = 16'hdead;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < TOTAL; i++) begin
            if (gap_mode == 1 || (gap_mode == 3 && $urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                tick();
            end
            start = (i == stray_at);
            in_valid = 1'b1;
            in_data = words[i];
            tick();
            start = 1'b0;
        end
        in_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("done_seen", seen, 1);
        tick();
    endtask

    logic [DW-1:0] seq [TOTAL];
    logic [DW-1:0] ones [TOTAL];
    logic [DW-1:0] rnd [TOTAL];

    initial begin
        for (int i = 0; i < TOTAL; i++) begin
            seq[i] = DW'(i + 1);
            ones[i] = 16'hffff;
        end

        #12;
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_waddr", w_addr, 0);
        chk("rst_bdata", b_data, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = DW'($urandom);
            tick();
        end
        in_valid = 1'b0;
        chk("idle_checksum", checksum, 0);
        chk("idle_ready", in_ready, 0);

        run_load(seq, 0, -1);
        chk("seq_checksum", checksum, 36);
        run_load(seq, 1, -1);
        chk("gap_checksum", checksum, 36);
        run_load(seq, 2, -1);
        chk("startvalid_checksum", checksum, 36);
        run_load(ones, 0, -1);
        chk("wrap_checksum", checksum, 16'hfff8);
        run_load(seq, 0, 4);
        chk("stray_checksum", checksum, 36);

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = seq[i];
            tick();
        end
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_ready", in_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_checksum", checksum, 0);
        chk("arst_bwe", b_we, 0);
        chk("arst_waddr", w_addr, 0);
        chk("arst_wdata", w_data, 0);
        tick();
        reset = 1'b0;
        tick();
        run_load(seq, 0, -1);
        chk("reload_checksum", checksum, 36);

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < TOTAL; i++) rnd[i] = DW'($urandom);
            run_load(rnd, 3, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TOTAL - 1)) : -1);
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
